// File: rtl/nn_mem_pkg.sv
// Shared defaults, bank-count constant and status enums for the per-stage memory block.
package nn_mem_pkg;

    localparam int unsigned TAP_W_DEF   = 384;
    localparam int unsigned TAP_AW_DEF  = 5;
    localparam int unsigned BIAS_W_DEF  = 32;
    localparam int unsigned BIAS_AW_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned DATA_AW_DEF = 9;

    localparam int unsigned NUM_BANKS = 2;

    // Protocol error causes, for assertion messages and coverage only
    typedef enum logic [1:0] {
        WR_FULL     = 2'd0,
        COMMIT_FULL = 2'd1,
        REL_EMPTY   = 2'd2,
        RD_EMPTY    = 2'd3
    } err_cause_e;

    // Number of committed data banks
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } bank_cnt_e;

endpackage

// File: rtl/nn_mem_1r1w.sv
// Simple dual-port RAM: read-first, registered read data with a matching valid bit.
module nn_mem_1r1w #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          rd_vld
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];

    // Storage is not reset; NBA update makes a same-address read return the old word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/nn_stage_mem_pp.sv
// Per-stage tap/bias/data storage; data memory is a ping-pong pair of banks with commit/release handshakes.
module nn_stage_mem_pp
    import nn_mem_pkg::*;
#(
    parameter int unsigned TAP_W   = TAP_W_DEF,
    parameter int unsigned TAP_AW  = TAP_AW_DEF,
    parameter int unsigned BIAS_W  = BIAS_W_DEF,
    parameter int unsigned BIAS_AW = BIAS_AW_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DATA_AW = DATA_AW_DEF
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               tap_wr_en,
    input  logic [TAP_AW-1:0]  tap_wr_addr,
    input  logic [TAP_W-1:0]   tap_wr_data,
    input  logic               tap_rd_en,
    input  logic [TAP_AW-1:0]  tap_rd_addr,
    output logic [TAP_W-1:0]   tap_rd_data,
    output logic               tap_rd_vld,

    input  logic               bias_wr_en,
    input  logic [BIAS_AW-1:0] bias_wr_addr,
    input  logic [BIAS_W-1:0]  bias_wr_data,
    input  logic               bias_rd_en,
    input  logic [BIAS_AW-1:0] bias_rd_addr,
    output logic [BIAS_W-1:0]  bias_rd_data,
    output logic               bias_rd_vld,

    input  logic               data_wr_en,
    input  logic [DATA_AW-1:0] data_wr_addr,
    input  logic [DATA_W-1:0]  data_wr_data,
    input  logic               data_commit,
    output logic               data_wr_rdy,
    input  logic               data_rd_en,
    input  logic [DATA_AW-1:0] data_rd_addr,
    input  logic               data_release,
    output logic               data_rd_avail,
    output logic [DATA_W-1:0]  data_rd_data,
    output logic               data_rd_vld,
    output logic               data_err
);

    localparam int unsigned DATA_RAM_AW = DATA_AW + $clog2(NUM_BANKS);

    bank_cnt_e cnt, cnt_n;
    logic      wr_bank, wr_bank_n;
    logic      rd_bank, rd_bank_n;
    logic      err_n;

    logic      full;
    logic      empty;
    logic      commit_ok;
    logic      rel_ok;
    logic      data_wr_ok;
    logic      data_rd_ok;

    assign full       = (cnt == CNT_FULL);
    assign empty      = (cnt == CNT_EMPTY);
    assign commit_ok  = data_commit  && !full;
    assign rel_ok     = data_release && !empty;
    assign data_wr_ok = data_wr_en   && !full;
    assign data_rd_ok = data_rd_en   && !empty;

    assign data_wr_rdy   = !full;
    assign data_rd_avail = !empty;

    nn_mem_1r1w #(.W(TAP_W), .AW(TAP_AW)) u_tap (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tap_wr_en),
        .wr_addr (tap_wr_addr),
        .wr_data (tap_wr_data),
        .rd_en   (tap_rd_en),
        .rd_addr (tap_rd_addr),
        .rd_data (tap_rd_data),
        .rd_vld  (tap_rd_vld)
    );

    nn_mem_1r1w #(.W(BIAS_W), .AW(BIAS_AW)) u_bias (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bias_wr_en),
        .wr_addr (bias_wr_addr),
        .wr_data (bias_wr_data),
        .rd_en   (bias_rd_en),
        .rd_addr (bias_rd_addr),
        .rd_data (bias_rd_data),
        .rd_vld  (bias_rd_vld)
    );

    // Bank select is the RAM address MSB; both use the pre-handshake bank bits
    nn_mem_1r1w #(.W(DATA_W), .AW(DATA_RAM_AW)) u_data (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (data_wr_ok),
        .wr_addr ({wr_bank, data_wr_addr}),
        .wr_data (data_wr_data),
        .rd_en   (data_rd_ok),
        .rd_addr ({rd_bank, data_rd_addr}),
        .rd_data (data_rd_data),
        .rd_vld  (data_rd_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= CNT_EMPTY;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            data_err <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            wr_bank  <= wr_bank_n;
            rd_bank  <= rd_bank_n;
            data_err <= err_n;
        end
    end

    // Commit and release are both judged against the current count
    always_comb begin
        cnt_n     = cnt;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        err_n     = data_err;

        if (commit_ok) begin
            wr_bank_n = !wr_bank;
        end
        if (rel_ok) begin
            rd_bank_n = !rd_bank;
        end

        case (cnt)
            CNT_EMPTY: if (commit_ok) cnt_n = CNT_ONE;
            CNT_ONE: begin
                if (commit_ok && !rel_ok) begin
                    cnt_n = CNT_FULL;
                end else if (rel_ok && !commit_ok) begin
                    cnt_n = CNT_EMPTY;
                end
            end
            CNT_FULL:  if (rel_ok) cnt_n = CNT_ONE;
            default:   cnt_n = CNT_EMPTY;
        endcase

        if ((data_wr_en && full) || (data_commit && full) ||
            (data_release && empty) || (data_rd_en && empty)) begin
            err_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_nn_stage_mem_pp.sv
// Directed, table-driven bench for nn_stage_mem_pp: tap/bias ports, ping-pong data banks, errors, reset.
module tb_nn_stage_mem_pp;

    localparam int unsigned TAP_W   = 384;
    localparam int unsigned TAP_AW  = 5;
    localparam int unsigned BIAS_W  = 32;
    localparam int unsigned BIAS_AW = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DATA_AW = 9;

    logic               clk;
    logic               reset;
    logic               tap_wr_en, tap_rd_en, tap_rd_vld;
    logic [TAP_AW-1:0]  tap_wr_addr, tap_rd_addr;
    logic [TAP_W-1:0]   tap_wr_data, tap_rd_data;
    logic               bias_wr_en, bias_rd_en, bias_rd_vld;
    logic [BIAS_AW-1:0] bias_wr_addr, bias_rd_addr;
    logic [BIAS_W-1:0]  bias_wr_data, bias_rd_data;
    logic               data_wr_en, data_commit, data_wr_rdy;
    logic               data_rd_en, data_release, data_rd_avail, data_rd_vld, data_err;
    logic [DATA_AW-1:0] data_wr_addr, data_rd_addr;
    logic [DATA_W-1:0]  data_wr_data, data_rd_data;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    nn_stage_mem_pp dut (
        .clk           (clk),
        .reset         (reset),
        .tap_wr_en     (tap_wr_en),
        .tap_wr_addr   (tap_wr_addr),
        .tap_wr_data   (tap_wr_data),
        .tap_rd_en     (tap_rd_en),
        .tap_rd_addr   (tap_rd_addr),
        .tap_rd_data   (tap_rd_data),
        .tap_rd_vld    (tap_rd_vld),
        .bias_wr_en    (bias_wr_en),
        .bias_wr_addr  (bias_wr_addr),
        .bias_wr_data  (bias_wr_data),
        .bias_rd_en    (bias_rd_en),
        .bias_rd_addr  (bias_rd_addr),
        .bias_rd_data  (bias_rd_data),
        .bias_rd_vld   (bias_rd_vld),
        .data_wr_en    (data_wr_en),
        .data_wr_addr  (data_wr_addr),
        .data_wr_data  (data_wr_data),
        .data_commit   (data_commit),
        .data_wr_rdy   (data_wr_rdy),
        .data_rd_en    (data_rd_en),
        .data_rd_addr  (data_rd_addr),
        .data_release  (data_release),
        .data_rd_avail (data_rd_avail),
        .data_rd_data  (data_rd_data),
        .data_rd_vld   (data_rd_vld),
        .data_err      (data_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               bias;
        logic               we;
        logic [TAP_AW-1:0]  wa;
        logic [TAP_W-1:0]   wd;
        logic               re;
        logic [TAP_AW-1:0]  ra;
        logic               e_vld;
        logic [TAP_W-1:0]   e_data;
    } trow_t;

    typedef struct {
        logic               we;
        logic [DATA_AW-1:0] wa;
        logic [DATA_W-1:0]  wd;
        logic               cm;
        logic               re;
        logic [DATA_AW-1:0] ra;
        logic               rl;
        logic               e_vld;
        logic [DATA_W-1:0]  e_data;
        logic               e_rdy;
        logic               e_avail;
        logic               e_err;
    } drow_t;

    trow_t trows[9];
    drow_t drows[17];

    task automatic chk(input string name, input logic [TAP_W-1:0] act, input logic [TAP_W-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tap_wr_en = 0; tap_wr_addr = '0; tap_wr_data = '0; tap_rd_en = 0; tap_rd_addr = '0;
        bias_wr_en = 0; bias_wr_addr = '0; bias_wr_data = '0; bias_rd_en = 0; bias_rd_addr = '0;
        data_wr_en = 0; data_wr_addr = '0; data_wr_data = '0; data_commit = 0;
        data_rd_en = 0; data_rd_addr = '0; data_release = 0;
    endtask

    function automatic trow_t mk_t(logic b, logic we, int wa, logic [TAP_W-1:0] wd,
                                   logic re, int ra, logic ev, logic [TAP_W-1:0] ed);
        trow_t r;
        r.bias = b; r.we = we; r.wa = TAP_AW'(wa); r.wd = wd;
        r.re = re; r.ra = TAP_AW'(ra); r.e_vld = ev; r.e_data = ed;
        return r;
    endfunction

    function automatic drow_t mk_d(logic we, int wa, int wd, logic cm, logic re, int ra, logic rl,
                                   logic ev, int ed, logic erdy, logic eav, logic eerr);
        drow_t r;
        r.we = we; r.wa = DATA_AW'(wa); r.wd = DATA_W'(wd); r.cm = cm;
        r.re = re; r.ra = DATA_AW'(ra); r.rl = rl;
        r.e_vld = ev; r.e_data = DATA_W'(ed); r.e_rdy = erdy; r.e_avail = eav; r.e_err = eerr;
        return r;
    endfunction

    task automatic run_trow(input int i);
        trow_t r;
        r = trows[i];
        idle_inputs();
        if (r.bias) begin
            bias_wr_en = r.we; bias_wr_addr = BIAS_AW'(r.wa); bias_wr_data = BIAS_W'(r.wd);
            bias_rd_en = r.re; bias_rd_addr = BIAS_AW'(r.ra);
        end else begin
            tap_wr_en = r.we; tap_wr_addr = r.wa; tap_wr_data = r.wd;
            tap_rd_en = r.re; tap_rd_addr = r.ra;
        end
        step();
        idle_inputs();
        if (r.bias) begin
            chk($sformatf("trow%0d bias_vld", i), TAP_W'(bias_rd_vld), TAP_W'(r.e_vld));
            chk($sformatf("trow%0d bias_data", i), TAP_W'(bias_rd_data), r.e_data);
        end else begin
            chk($sformatf("trow%0d tap_vld", i), TAP_W'(tap_rd_vld), TAP_W'(r.e_vld));
            chk($sformatf("trow%0d tap_data", i), tap_rd_data, r.e_data);
        end
    endtask

    task automatic run_drow(input int i);
        drow_t r;
        r = drows[i];
        idle_inputs();
        data_wr_en = r.we; data_wr_addr = r.wa; data_wr_data = r.wd; data_commit = r.cm;
        data_rd_en = r.re; data_rd_addr = r.ra; data_release = r.rl;
        step();
        idle_inputs();
        chk($sformatf("drow%0d vld", i),   TAP_W'(data_rd_vld),   TAP_W'(r.e_vld));
        chk($sformatf("drow%0d data", i),  TAP_W'(data_rd_data),  TAP_W'(r.e_data));
        chk($sformatf("drow%0d rdy", i),   TAP_W'(data_wr_rdy),   TAP_W'(r.e_rdy));
        chk($sformatf("drow%0d avail", i), TAP_W'(data_rd_avail), TAP_W'(r.e_avail));
        chk($sformatf("drow%0d err", i),   TAP_W'(data_err),      TAP_W'(r.e_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " tap_vld"},   TAP_W'(tap_rd_vld),    '0);
        chk({tag, " tap_data"},  tap_rd_data,           '0);
        chk({tag, " bias_vld"},  TAP_W'(bias_rd_vld),   '0);
        chk({tag, " bias_data"}, TAP_W'(bias_rd_data),  '0);
        chk({tag, " data_vld"},  TAP_W'(data_rd_vld),   '0);
        chk({tag, " data_data"}, TAP_W'(data_rd_data),  '0);
        chk({tag, " wr_rdy"},    TAP_W'(data_wr_rdy),   TAP_W'(1));
        chk({tag, " rd_avail"},  TAP_W'(data_rd_avail), '0);
        chk({tag, " err"},       TAP_W'(data_err),      '0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic fill_bank(input int offset);
        for (int i = 0; i < (1 << DATA_AW); i++) begin
            data_wr_en = 1'b1; data_wr_addr = DATA_AW'(i); data_wr_data = DATA_W'(i + offset);
            step();
        end
        idle_inputs();
        data_commit = 1'b1;
        step();
        idle_inputs();
    endtask

    initial begin
        logic [TAP_W-1:0] a5;
        a5 = {48{8'hA5}};

        // Tap and bias: same-address write/read returns the old word; data holds while vld is low
        trows[0] = mk_t(0, 1, 7, 384'h11, 0, 0, 0, '0);
        trows[1] = mk_t(0, 1, 3, a5,      0, 0, 0, '0);
        trows[2] = mk_t(0, 0, 0, '0,      1, 3, 1, a5);
        trows[3] = mk_t(0, 1, 7, 384'h22, 1, 7, 1, 384'h11);
        trows[4] = mk_t(0, 0, 0, '0,      1, 7, 1, 384'h22);
        trows[5] = mk_t(0, 0, 0, '0,      0, 0, 0, 384'h22);
        trows[6] = mk_t(1, 1, 15, 384'hDEADBEEF, 0, 0, 0, '0);
        trows[7] = mk_t(1, 1, 15, 384'h12345678, 1, 15, 1, 384'hDEADBEEF);
        trows[8] = mk_t(1, 0, 0, '0,      1, 15, 1, 384'h12345678);

        // Starting from cnt=2, bank0 = i, bank1 = i+1000
        drows[0]  = mk_d(0, 0, 0,    0, 1, 5, 0,  1, 5,    0, 1, 0);
        drows[1]  = mk_d(1, 5, 9999, 1, 0, 0, 0,  0, 5,    0, 1, 1);
        drows[2]  = mk_d(0, 0, 0,    0, 1, 5, 0,  1, 5,    0, 1, 1);
        drows[3]  = mk_d(0, 0, 0,    0, 1, 6, 1,  1, 6,    1, 1, 1);
        drows[4]  = mk_d(0, 0, 0,    0, 1, 5, 0,  1, 1005, 1, 1, 1);
        drows[5]  = mk_d(0, 0, 0,    0, 0, 0, 0,  0, 1005, 1, 1, 1);
        drows[6]  = mk_d(1, 7, 77,   1, 0, 0, 0,  0, 1005, 0, 1, 1);
        // After a mid-operation reset: cnt=0, banks 0, RAM kept
        drows[7]  = mk_d(0, 0, 0,    1, 0, 0, 0,  0, 0,    1, 1, 0);
        drows[8]  = mk_d(0, 0, 0,    0, 1, 7, 0,  1, 77,   1, 1, 0);
        drows[9]  = mk_d(0, 0, 0,    0, 1, 5, 0,  1, 5,    1, 1, 0);
        drows[10] = mk_d(1, 0, 'hB1, 0, 0, 0, 0,  0, 5,    1, 1, 0);
        drows[11] = mk_d(1, 1, 'hB2, 1, 0, 0, 1,  0, 5,    1, 1, 0);
        drows[12] = mk_d(0, 0, 0,    0, 1, 0, 0,  1, 'hB1, 1, 1, 0);
        drows[13] = mk_d(0, 0, 0,    0, 1, 1, 0,  1, 'hB2, 1, 1, 0);
        drows[14] = mk_d(0, 0, 0,    0, 1, 2, 1,  1, 1002, 1, 0, 0);
        // Underflow right after reset
        drows[15] = mk_d(0, 0, 0,    0, 1, 0, 1,  0, 0,    1, 0, 1);
        drows[16] = mk_d(0, 0, 0,    0, 0, 0, 0,  0, 0,    1, 0, 1);

        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 chk_reset_vals("reset");
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_trow(i);

        fill_bank(0);
        chk("bank0 commit avail", TAP_W'(data_rd_avail), TAP_W'(1));
        chk("bank0 commit rdy",   TAP_W'(data_wr_rdy),   TAP_W'(1));
        fill_bank(1000);
        chk("bank1 commit rdy",   TAP_W'(data_wr_rdy),   '0);
        chk("bank1 commit err",   TAP_W'(data_err),      '0);

        for (int i = 0; i <= 6; i++) run_drow(i);

        // Reset asserted with cnt=2 and a data read just returned
        data_rd_en = 1'b1; data_rd_addr = DATA_AW'(5);
        step();
        idle_inputs();
        chk("pre-reset data vld", TAP_W'(data_rd_vld), TAP_W'(1));
        chk("pre-reset wr_rdy",   TAP_W'(data_wr_rdy), '0);
        tap_rd_en = 1'b1; tap_rd_addr = TAP_AW'(3);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midreset");
        step();
        idle_inputs();
        step();
        reset = 1'b1;
        step();
        chk("post-reset tap vld", TAP_W'(tap_rd_vld), '0);

        for (int i = 7; i <= 14; i++) run_drow(i);

        pulse_reset();
        for (int i = 15; i <= 16; i++) run_drow(i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nn_stage_mem_pp.md
# nn_stage_mem_pp

Parametrised per-stage memory block for the fully-connected layer pipeline: tap, bias and data storage behind one clock, with widths and depths set by parameters. The data memory is double-buffered: the previous stage fills one bank while the MAC array reads the other, with commit/release handshakes and error flags. Every read port has a registered `rd_vld`. It replaces the fixed-size per-design stage memory wrappers, and sits between the stage controller and the MAC array.

## Interface
- `TAP_W`, 384: tap word width
- `TAP_AW`, 5: tap address width (depth 2^TAP_AW)
- `BIAS_W`, 32: bias word width
- `BIAS_AW`, 4: bias address width
- `DATA_W`, 32: data word width
- `DATA_AW`, 9: data address width per bank
- `clk`  in  1  sole clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `tap_wr_en`, `tap_wr_addr[TAP_AW]`, `tap_wr_data[TAP_W]`  in  tap write port
- `tap_rd_en`, `tap_rd_addr[TAP_AW]`  in  tap read request
- `tap_rd_data`  out  TAP_W  tap read data
- `tap_rd_vld`  out  1  tap read data valid
- `bias_wr_en`, `bias_wr_addr`, `bias_wr_data`, `bias_rd_en`, `bias_rd_addr`  in  bias ports, same shape as tap
- `bias_rd_data`  out  BIAS_W  bias read data
- `bias_rd_vld`  out  1  bias read data valid
- `data_wr_en`, `data_wr_addr[DATA_AW]`, `data_wr_data[DATA_W]`  in  write into the fill bank
- `data_commit`  in  1  pulse: fill bank complete, hand it to the reader
- `data_wr_rdy`  out  1  a fill bank is free (committed count < 2)
- `data_rd_en`, `data_rd_addr[DATA_AW]`  in  read from the active bank
- `data_release`  in  1  pulse: reader finished with the active bank
- `data_rd_avail`  out  1  an active bank holds committed data (count ≥ 1)
- `data_rd_data`  out  DATA_W  data read data
- `data_rd_vld`  out  1  data read data valid
- `data_err`  out  1  sticky protocol error; cleared only by reset

## Operation
- **Tap and bias memories:** simple dual-port, one write and one read per cycle.
  - Same-cycle read and write to the same address is read-first: the read returns the old word.
- **Data memory:** one RAM of depth 2·2^DATA_AW. The bank bit is the address MSB.
- **Bank state registers:**
  - `wr_bank` (1 bit)
  - `rd_bank` (1 bit)
  - `cnt` (2 bits, committed banks, 0..2)
  - Invariant: `rd_bank == wr_bank ^ cnt[0]` when `cnt` = 1; `rd_bank == wr_bank` when `cnt` ∈ {0, 2}.
- **Data writes:**
  - `data_wr_en` with `cnt` < 2 writes `{wr_bank, data_wr_addr}`.
  - `data_wr_en` with `cnt` = 2 is dropped and sets `data_err`.
- **Commit:**
  - `data_commit` with `cnt` < 2: `wr_bank` toggles, `cnt` increments.
  - `data_commit` with `cnt` = 2: ignored, sets `data_err`.
- **Release:**
  - `data_release` with `cnt` > 0: `rd_bank` toggles, `cnt` decrements.
  - `data_release` with `cnt` = 0: ignored, sets `data_err`.
- **Simultaneous commit and release:**
  - With `cnt` = 1: both banks toggle, `cnt` stays 1.
  - With `cnt` = 0: the commit is legal; the release is evaluated against the pre-update `cnt`, so it is an error. Result: `cnt` = 1, `data_err` = 1.
  - With `cnt` = 2: the release is legal and the commit is an error. Result: `cnt` = 1, `data_err` = 1.
- **Data reads:**
  - `data_rd_en` with `cnt` ≥ 1 reads `{rd_bank, data_rd_addr}`.
  - `data_rd_en` with `cnt` = 0 is ignored: `data_rd_vld` stays low and `data_err` is set.
  - A write in the same cycle as a commit lands in the old `wr_bank`.
  - A read in the same cycle as a release uses the old `rd_bank`.
- **Status outputs:** `data_wr_rdy` = (`cnt` != 2) and `data_rd_avail` = (`cnt` != 0), both decoded combinationally from registers.

## Timing
- **Read latency:** exactly 1 cycle on all three ports. A request sampled at edge N gives `*_rd_data` and `*_rd_vld` = 1 after edge N+1.
- **Read data hold:** `*_rd_data` holds its last value while `*_rd_vld` = 0.
- **Write visibility:** a write at edge N is visible to a read issued at edge N+1 or later.
- **Handshake effect:** commit or release at edge N changes `cnt`, the bank bits, `data_wr_rdy` and `data_rd_avail` after edge N.
- **Reset values (asserted asynchronously):**
  - All `*_rd_data` = 0
  - All `*_rd_vld` = 0
  - `cnt` = 0, `wr_bank` = 0, `rd_bank` = 0
  - `data_wr_rdy` = 1, `data_rd_avail` = 0, `data_err` = 0
- **RAM contents:** not reset.
- **Reset mid-read:** a read in flight is discarded; `*_rd_vld` = 0 on the first edge after deassertion.

## Structure
- **Shared package `nn_mem_pkg`:**
  - Default width/depth localparams
  - Bank-count constant (2)
  - Error-cause enum (`WR_FULL`, `COMMIT_FULL`, `REL_EMPTY`, `RD_EMPTY`), used for assertion messages and coverage only
- **Sub-module `nn_mem_1r1w`:**
  - Parameters `W` and `AW`; read-first, registered output, valid pipeline, async active-low reset on output registers only.
  - Instantiated three times: tap, bias, and data with `AW` = DATA_AW+1.
- **Top level:** holds only the bank FSM, address concatenation and error logic.

## Test plan
- **Tap read/write:** write tap addr 3 = 384'hA5…A5, read addr 3 next cycle → `tap_rd_vld` one cycle later, data A5…A5. Same-cycle write 1 and read addr 7 (old value 0x11) → returns 0x11.
- **Ping-pong fill and drain:**
  - Fill bank 0 with addr i → i for i = 0..511, then commit → `data_rd_avail` = 1, `data_wr_rdy` = 1.
  - Fill bank 1 with i + 1000, then commit → `data_wr_rdy` = 0.
  - Read addr 5 → 5. Release, then read addr 5 → 1005.
- **Overflow:** with `cnt` = 2, write and commit → memory unchanged, `cnt` = 2, `data_err` = 1.
- **Underflow:** after reset, `data_rd_en` and `data_release` → `data_rd_vld` = 0, `cnt` = 0, `data_err` = 1.
- **Simultaneous handshakes:** with `cnt` = 1, pulse commit and release in the same cycle → `cnt` = 1, both bank bits toggled, no error. Read addr 0 returns the newly committed bank's value.
- **Reset mid-operation:** assert `reset` low with `cnt` = 2 and a read in flight → all outputs at reset values immediately. After release, `data_wr_rdy` = 1 and previously written RAM data is still readable after a commit.
